// File: rtl/pc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pc_pkg
//  Description : Shared types for the fetch-stage PC unit: the resolved PC
//                operation enum, the default reset vector and the priority
//                encoder that turns raw control strobes into one operation.
//  Revision    : 1.0  initial release
// ============================================================================
package pc_pkg;

  typedef enum logic [2:0] {
    PC_HOLD = 3'd0,
    PC_INC  = 3'd1,
    PC_LD   = 3'd2,
    PC_CALL = 3'd3,
    PC_RET  = 3'd4
  } pc_op_t;

  localparam int unsigned PC_RESET_VEC_DEF = 0;

  // ret > call > ld > inc > hold. Stall is handled by the caller because it
  // also freezes the sticky flags, not only the PC operation.
  function automatic pc_op_t resolve_op(input logic ret, input logic call,
                                        input logic ld, input logic inc);
    pc_op_t op;
    op = PC_HOLD;
    if (ret)       op = PC_RET;
    else if (call) op = PC_CALL;
    else if (ld)   op = PC_LD;
    else if (inc)  op = PC_INC;
    return op;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ras_stack.sv
`default_nettype none
// ============================================================================
//  Module      : ras_stack
//  Description : Circular return-address stack with a top pointer and a
//                saturating level counter. A push while full overwrites the
//                oldest entry; a pop while empty is ignored.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                push, pop       - stack operations (pop wins if both)
//                push_data       - value written on push
//                top_data        - entry under the top pointer
//                level           - valid entries, 0..DEPTH
//                full, empty     - decoded from level
//  Revision    : 1.0  initial release
// ============================================================================
module ras_stack #(
  parameter int DATA_W = 10,
  parameter int DEPTH  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DATA_W-1:0]          push_data,
  output logic [DATA_W-1:0]          top_data,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              do_pop, do_push;
  logic [PTR_W-1:0]  wr_ptr;

  assign full     = (level_q == LVL_W'(DEPTH));
  assign empty    = (level_q == '0);
  assign level    = level_q;
  assign top_data = mem_q[ptr_q];

  // DEPTH is a power of two, so natural PTR_W-bit wrap gives modulo DEPTH.
  assign do_pop  = pop && !empty;
  assign do_push = push && !pop;
  assign wr_ptr  = ptr_q + PTR_W'(1);

  always_comb begin
    ptr_d   = ptr_q;
    level_d = level_q;
    if (do_pop) begin
      ptr_d   = ptr_q - PTR_W'(1);
      level_d = level_q - LVL_W'(1);
    end else if (do_push) begin
      ptr_d = wr_ptr;
      if (!full) level_d = level_q + LVL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q   <= '0;
      level_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      level_q <= level_d;
    end
  end

  // Contents carry no reset; only the pointer and level define validity.
  always_ff @(posedge clk) begin
    if (!rst && do_push) mem_q[wr_ptr] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/pc_ras_unit.sv
`default_nettype none
// ============================================================================
//  Module      : pc_ras_unit
//  Description : Fetch-stage program counter with N-way next-address select,
//                load / increment / stall, and a hardware return-address
//                stack for CALL / RET with sticky overflow/underflow flags.
//  Ports       : clk, rst            - clock, synchronous active-high reset
//                src_addr, pc_sel    - packed address sources and select
//                pc_ld, pc_inc       - load selected source / increment
//                call, ret           - push PC+1 and jump / pop into PC
//                stall, clr_err      - freeze all state / clear sticky flags
//                pc_count            - current PC
//                ras_level/full/empty- return stack occupancy
//                ras_ovf, ras_unf    - sticky push-while-full / pop-while-empty
//  Revision    : 1.0  initial release
// ============================================================================
module pc_ras_unit
  import pc_pkg::*;
#(
  parameter int          ADDR_W    = 10,
  parameter int          NUM_SRC   = 4,
  parameter int          SEL_W     = $clog2(NUM_SRC),  // derived; do not override
  parameter int          RAS_DEPTH = 8,
  parameter int unsigned RESET_VEC = PC_RESET_VEC_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_SRC*ADDR_W-1:0]   src_addr,
  input  logic [SEL_W-1:0]            pc_sel,
  input  logic                        pc_ld,
  input  logic                        pc_inc,
  input  logic                        call,
  input  logic                        ret,
  input  logic                        stall,
  input  logic                        clr_err,
  output logic [ADDR_W-1:0]           pc_count,
  output logic [$clog2(RAS_DEPTH):0]  ras_level,
  output logic                        ras_full,
  output logic                        ras_empty,
  output logic                        ras_ovf,
  output logic                        ras_unf
);

  localparam logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_VEC);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic [ADDR_W-1:0] sel_src;
  logic [ADDR_W-1:0] ras_top;
  logic              ras_push, ras_pop;
  pc_op_t            op;

  // Out-of-range selects (non power-of-two NUM_SRC) fall back to source 0.
  always_comb begin
    sel_src = src_addr[ADDR_W-1:0];
    for (int k = 1; k < NUM_SRC; k++) begin
      if (pc_sel == SEL_W'(k)) sel_src = src_addr[k*ADDR_W +: ADDR_W];
    end
  end

  assign op = stall ? PC_HOLD : resolve_op(ret, call, pc_ld, pc_inc);

  always_comb begin
    pc_d     = pc_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    ras_push = 1'b0;
    ras_pop  = 1'b0;
    // Clear first so that an error raised in the same cycle wins.
    if (!stall && clr_err) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
    case (op)
      PC_RET: begin
        ras_pop = 1'b1;
        if (ras_empty) begin
          pc_d  = RESET_PC;
          unf_d = 1'b1;
        end else begin
          pc_d = ras_top;
        end
      end
      PC_CALL: begin
        ras_push = 1'b1;
        pc_d     = sel_src;
        if (ras_full) ovf_d = 1'b1;
      end
      PC_LD:   pc_d = sel_src;
      PC_INC:  pc_d = pc_q + ADDR_W'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q  <= RESET_PC;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  ras_stack #(
    .DATA_W (ADDR_W),
    .DEPTH  (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_q + ADDR_W'(1)),
    .top_data  (ras_top),
    .level     (ras_level),
    .full      (ras_full),
    .empty     (ras_empty)
  );

  assign pc_count = pc_q;
  assign ras_ovf  = ovf_q;
  assign ras_unf  = unf_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_ras_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_ras_unit
//  Description : Directed self-checking bench for pc_ras_unit with default
//                parameters (ADDR_W=10, NUM_SRC=4, RAS_DEPTH=8, RESET_VEC=0).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pc_ras_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [39:0] src_addr;
  logic [1:0]  pc_sel;
  logic        pc_ld, pc_inc, call, ret, stall, clr_err;
  logic [9:0]  pc_count;
  logic [3:0]  ras_level;
  logic        ras_full, ras_empty, ras_ovf, ras_unf;

  int n_checks = 0;
  int n_pass   = 0;

  pc_ras_unit dut (
    .clk       (clk),
    .rst       (rst),
    .src_addr  (src_addr),
    .pc_sel    (pc_sel),
    .pc_ld     (pc_ld),
    .pc_inc    (pc_inc),
    .call      (call),
    .ret       (ret),
    .stall     (stall),
    .clr_err   (clr_err),
    .pc_count  (pc_count),
    .ras_level (ras_level),
    .ras_full  (ras_full),
    .ras_empty (ras_empty),
    .ras_ovf   (ras_ovf),
    .ras_unf   (ras_unf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_state(input string tag, input int pc, input int lvl,
                           input int ovf, input int unf);
    chk({tag, ".pc"},    32'(pc_count),  32'(pc));
    chk({tag, ".level"}, 32'(ras_level), 32'(lvl));
    chk({tag, ".empty"}, 32'(ras_empty), 32'(lvl == 0));
    chk({tag, ".full"},  32'(ras_full),  32'(lvl == 8));
    chk({tag, ".ovf"},   32'(ras_ovf),   32'(ovf));
    chk({tag, ".unf"},   32'(ras_unf),   32'(unf));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int k, input int v);
    src_addr[k*10 +: 10] = 10'(v);
  endtask

  task automatic ctl_off();
    pc_ld = 0; pc_inc = 0; call = 0; ret = 0; stall = 0; clr_err = 0;
  endtask

  initial begin
    ctl_off();
    src_addr = '0;
    pc_sel   = 0;
    rst      = 1;
    tick(); tick();
    rst = 0;
    chk_state("reset", 0, 0, 0, 0);

    // Increment and wrap
    pc_inc = 1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk_state("inc", i, 0, 0, 0);
    end
    pc_inc = 0;
    set_src(0, 1023); pc_sel = 0; pc_ld = 1; tick(); pc_ld = 0;
    chk_state("ld_max", 1023, 0, 0, 0);
    pc_inc = 1; tick(); pc_inc = 0;
    chk_state("wrap", 0, 0, 0, 0);

    // Single call / return
    set_src(0, 'h010); pc_ld = 1; tick(); pc_ld = 0;
    set_src(2, 'h1A0); pc_sel = 2; call = 1; tick(); call = 0;
    chk_state("call", 'h1A0, 1, 0, 0);
    ret = 1; tick(); ret = 0;
    chk_state("ret", 'h011, 0, 0, 0);

    // Nine nested calls into an eight-deep stack
    set_src(0, 0); pc_sel = 0; pc_ld = 1; tick(); pc_ld = 0;
    pc_sel = 1;
    for (int k = 1; k <= 9; k++) begin
      set_src(1, 'h40 + k - 1);
      call = 1; tick();
      chk_state("nest", 'h40 + k - 1, (k > 8) ? 8 : k, (k == 9) ? 1 : 0, 0);
    end
    call = 0;
    // Pushed values were 0x001, 0x041..0x048; 0x001 got overwritten.
    for (int j = 0; j < 8; j++) begin
      ret = 1; tick();
      chk_state("lifo", 'h48 - j, 7 - j, 1, 0);
    end
    tick();
    chk_state("unf", 0, 0, 1, 1);
    ret = 0;

    // Stall freezes everything, then the pending op (ret) executes
    set_src(0, 'h100); pc_sel = 0; pc_ld = 1; tick(); pc_ld = 0;
    set_src(1, 'h200); pc_sel = 1; call = 1; tick();
    chk_state("pre_stall", 'h200, 1, 1, 1);
    stall = 1; ret = 1; pc_inc = 1; clr_err = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_state("stall", 'h200, 1, 1, 1);
    end
    stall = 0; tick();
    chk_state("unstall", 'h101, 0, 0, 0);
    ctl_off();

    // call+ret together: ret wins, nothing pushed
    set_src(0, 'h054); pc_sel = 0; pc_ld = 1; tick(); pc_ld = 0;
    set_src(1, 'h300); pc_sel = 1; call = 1; tick();
    chk_state("call2", 'h300, 1, 0, 0);
    ret = 1; tick(); call = 0;
    chk_state("callret", 'h055, 0, 0, 0);
    tick();
    chk_state("nopush", 0, 0, 0, 1);
    clr_err = 1; tick();
    chk_state("clr_set_wins", 0, 0, 0, 1);
    ret = 0; tick();
    chk_state("clr", 0, 0, 0, 0);
    clr_err = 0;

    // Load beats increment
    set_src(2, 'h123); pc_sel = 2; pc_ld = 1; pc_inc = 1; tick(); ctl_off();
    chk_state("ld_inc", 'h123, 0, 0, 0);

    // Reset in the middle of activity
    pc_sel = 1;
    for (int k = 1; k <= 9; k++) begin
      set_src(1, 'h50 + k);
      call = 1; tick();
    end
    call = 0;
    ret = 1;
    for (int j = 0; j < 5; j++) tick();
    ret = 0;
    chk_state("pre_rst", 'h55, 3, 1, 0);
    rst = 1; call = 1; tick(); rst = 0; call = 0;
    chk_state("mid_rst", 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
